// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-operand hazard controller with counted multi-cycle stalls,
// taken-branch IF/ID flush, memory-busy freeze and a saturating stall counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LOAD_STALL = 1,
  parameter bit          BR_IN_ID   = 1'b1,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] IF_ID_Rs_addr,
  input  logic [REG_AW-1:0] IF_ID_Rt_addr,
  input  logic              IF_ID_uses_rt,
  input  logic              ID_branch,
  input  logic              branch_taken,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_RegWrite,
  input  logic [REG_AW-1:0] ID_EX_Wr_addr,
  input  logic              mem_busy,
  output logic              PC_Write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              isControl,
  output logic              pipe_hold,
  output logic [PERF_W-1:0] stall_count
);
  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  state_t     state_q, state_d, resume_q, resume_d, cur;
  logic [2:0] rem_q, rem_d;
  logic       src_hit, lu_haz, br_haz, stall_cyc;
  logic [3:0] lu_len, br_len, haz_len;

  assign src_hit = (ID_EX_Wr_addr != ZERO_ADDR) &&
                   ((ID_EX_Wr_addr == IF_ID_Rs_addr) ||
                    (IF_ID_uses_rt && (ID_EX_Wr_addr == IF_ID_Rt_addr)));
  assign lu_haz  = ID_EX_MemRead && src_hit;
  assign br_haz  = BR_IN_ID && ID_branch && ID_EX_RegWrite && src_hit;

  always_comb begin
    lu_len  = lu_haz ? 4'(LOAD_STALL) : 4'd0;
    br_len  = '0;
    if (br_haz) br_len = ID_EX_MemRead ? 4'(LOAD_STALL + 1) : 4'd1;
    haz_len = (lu_len > br_len) ? lu_len : br_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      resume_q <= RUN;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      rem_q    <= rem_d;
    end
  end

  // While frozen, the saved state is what runs once mem_busy drops.
  always_comb begin
    state_d     = state_q;
    resume_d    = resume_q;
    rem_d       = rem_q;
    PC_Write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    isControl   = 1'b1;
    pipe_hold   = 1'b0;
    stall_cyc   = 1'b0;
    cur         = (state_q == FREEZE) ? resume_q : state_q;
    if (rst) begin
      PC_Write    = 1'b0;
      IF_ID_write = 1'b0;
      isControl   = 1'b0;
    end else if (mem_busy) begin
      PC_Write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_hold   = 1'b1;
      stall_cyc   = 1'b1;
      state_d     = FREEZE;
      resume_d    = cur;
    end else begin
      case (cur)
        RUN: begin
          state_d = RUN;
          if (haz_len != 4'd0) begin
            PC_Write    = 1'b0;
            IF_ID_write = 1'b0;
            isControl   = 1'b0;
            stall_cyc   = 1'b1;
            if (haz_len > 4'd1) begin
              state_d = STALL;
              rem_d   = 3'(haz_len - 4'd1);
            end
          end else if (ID_branch && branch_taken) begin
            IF_ID_flush = 1'b1;
          end
        end
        STALL: begin
          PC_Write    = 1'b0;
          IF_ID_write = 1'b0;
          isControl   = 1'b0;
          stall_cyc   = 1'b1;
          rem_d       = rem_q - 3'd1;
          if (rem_q <= 3'd1) begin
            state_d = RUN;
            rem_d   = '0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_cyc),
    .clear(1'b0),
    .count(stall_count)
  );
endmodule
